serializador_medida: RTL

- Downstream consumer of the ultrasonic-interface measurement in the rangefinder top level.
- On a start pulse, latches the 3-digit BCD distance (12 bits) and transmits it over an asynchronous serial line as four ASCII characters: hundreds, tens, units, then '#'.
- Each character goes out as a 7E2 frame: 7 data bits, even parity, 2 stop bits.
- Asserts a one-cycle completion pulse when the last frame ends.

---
 rtl/serializador_medida_pkg.sv | 34 +++
 rtl/serializador_medida_tx_serial_7E2.sv | 72 +++++++
 rtl/serializador_medida.sv | 89 ++++++++
 3 files changed

// File: rtl/serializador_medida_pkg.sv
// Shared definitions for the measurement serializer: FSM state codes, ASCII
// constants and the 7E2 frame builder.
package serializador_medida_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL   = 4'h0,
    ST_CARREGA   = 4'h1,
    ST_TRANSMITE = 4'h2,
    ST_PROXIMO   = 4'h3,
    ST_FINAL     = 4'h4
  } estado_e;

  localparam logic [2:0]  ASCII_DIGIT_PREFIX = 3'b011;
  localparam logic [6:0]  ASCII_HASH         = 7'h23;
  localparam int unsigned FRAME_BITS         = 11;

  // Frame as sent LSB first: start, d0..d6, even parity, two stop bits.
  function automatic logic [FRAME_BITS-1:0] monta_quadro(input logic [6:0] dado);
    return {2'b11, ^dado, dado, 1'b0};
  endfunction

  // Character for message position idx: three BCD digits, then '#'.
  function automatic logic [6:0] caractere(input logic [1:0] idx, input logic [11:0] medida);
    logic [6:0] c;
    case (idx)
      2'd0:    c = {ASCII_DIGIT_PREFIX, medida[11:8]};
      2'd1:    c = {ASCII_DIGIT_PREFIX, medida[7:4]};
      2'd2:    c = {ASCII_DIGIT_PREFIX, medida[3:0]};
      default: c = ASCII_HASH;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serializador_medida_tx_serial_7E2.sv
// Single-character 7E2 transmitter: loads a frame on partida, holds each bit
// for BAUD_DIV cycles and pulses pronto in the last cycle of the second stop bit.
module tx_serial_7E2
  import serializador_medida_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dado,
  output logic       saida,
  output logic       pronto
);

  localparam int unsigned CntW   = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);
  localparam logic [3:0]      BitMax = 4'(FRAME_BITS - 1);

  logic                  ativo_q, ativo_d;
  logic [FRAME_BITS-1:0] quadro_q, quadro_d;
  logic [CntW-1:0]       tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic                  fim_bit;

  assign fim_bit = ativo_q && (tick_q == CntMax);
  assign pronto  = fim_bit && (bit_q == BitMax);
  // Line idles high whenever no frame is in flight, including right after reset.
  assign saida   = ativo_q ? quadro_q[0] : 1'b1;

  // Next state: load on partida, then tick through the bits shifting in idle ones.
  always_comb begin
    ativo_d  = ativo_q;
    quadro_d = quadro_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    if (partida) begin
      ativo_d  = 1'b1;
      quadro_d = monta_quadro(dado);
      tick_d   = '0;
      bit_d    = '0;
    end else if (ativo_q) begin
      if (fim_bit) begin
        tick_d = '0;
        if (bit_q == BitMax) begin
          ativo_d = 1'b0;
        end else begin
          bit_d    = bit_q + 4'd1;
          quadro_d = {1'b1, quadro_q[FRAME_BITS-1:1]};
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ativo_q  <= 1'b0;
      quadro_q <= '1;
      tick_q   <= '0;
      bit_q    <= '0;
    end else begin
      ativo_q  <= ativo_d;
      quadro_q <= quadro_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: rtl/serializador_medida.sv
// Message sequencer: latches a 3-digit BCD measurement and sends it as four
// 7E2 characters (hundreds, tens, units, '#'), then pulses pronto.
module serializador_medida
  import serializador_medida_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [11:0] dados,
  output logic        saida_serial,
  output logic        pronto,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  estado_e     estado_q, estado_d;
  logic [1:0]  indice_q, indice_d;
  logic [11:0] dados_q, dados_d;
  logic        partida;
  logic        tx_pronto;

  tx_serial_7E2 #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clock   (clock),
    .reset   (reset),
    .partida (partida),
    .dado    (caractere(indice_q, dados_q)),
    .saida   (saida_serial),
    .pronto  (tx_pronto)
  );

  assign ocupado   = (estado_q != ST_INICIAL);
  assign db_estado = estado_q;

  // Message FSM: next state, index/data updates and the one-cycle strobes.
  always_comb begin
    estado_d = estado_q;
    indice_d = indice_q;
    dados_d  = dados_q;
    partida  = 1'b0;
    pronto   = 1'b0;
    case (estado_q)
      ST_INICIAL: begin
        if (inicio) begin
          dados_d  = dados;
          indice_d = 2'd0;
          estado_d = ST_CARREGA;
        end
      end
      ST_CARREGA: begin
        partida  = 1'b1;
        estado_d = ST_TRANSMITE;
      end
      ST_TRANSMITE: begin
        if (tx_pronto) estado_d = ST_PROXIMO;
      end
      ST_PROXIMO: begin
        if (indice_q != 2'd3) begin
          indice_d = indice_q + 2'd1;
          estado_d = ST_CARREGA;
        end else begin
          estado_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        pronto   = 1'b1;
        estado_d = ST_INICIAL;
      end
      default: estado_d = ST_INICIAL;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      indice_q <= 2'd0;
      dados_q  <= 12'h000;
    end else begin
      estado_q <= estado_d;
      indice_q <= indice_d;
      dados_q  <= dados_d;
    end
  end

endmodule
